// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU: ALUcontrol codes, FSM state encodings
// and the shift-amount width helper.
package alu_pkg;

    localparam logic [3:0] ALU_NOP  = 4'b0000;
    localparam logic [3:0] ALU_EQ   = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_GE   = 4'b0011;
    localparam logic [3:0] ALU_GEU  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_ADD  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_SRL  = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1100;
    localparam logic [3:0] ALU_SUB  = 4'b1101;
    localparam logic [3:0] ALU_NE   = 4'b1110;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic int shamt_width(input int xlen);
        return $clog2(xlen);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational shifter for SLL/SRL/SRA by a variable amount; used as one step
// of the iterative shifter or as a full barrel shifter.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int AMT_W = 6
) (
    input  logic [XLEN-1:0]  value_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic [3:0]       op_i,
    output logic [XLEN-1:0]  value_o
);

    // NOTE: every path of a combinational block assigns its outputs (here via
    // the default arm) so no latch is inferred.
    always_comb begin
        case (op_i)
            ALU_SLL: value_o = value_i << amt_i;
            ALU_SRL: value_o = value_i >> amt_i;
            ALU_SRA: value_o = $signed(value_i) >>> amt_i;
            default: value_o = value_i;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle EX-stage ALU with valid/ready on both sides. Shifts run SHIFT_STEP
// bits per cycle unless ALU_BARREL_SHIFT_EN selects a single-cycle barrel shifter.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            cond,
    output logic            illegal
);

    localparam int SW = shamt_width(XLEN);
    localparam int AW = SW + 1;

    logic [1:0]      state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            cond_q, cond_d;
    logic            illegal_q, illegal_d;

    logic            accept;
    logic            is_shift;
    logic [SW-1:0]   shamt;
    logic            lt, ltu;
    logic [XLEN-1:0] alu_res;
    logic            alu_cond, alu_ill;
    logic [XLEN-1:0] shift_out;

    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign shamt    = op_b[SW-1:0];
    assign is_shift = (alu_ctrl == ALU_SLL) || (alu_ctrl == ALU_SRL) || (alu_ctrl == ALU_SRA);
    assign lt       = $signed(op_a) < $signed(op_b);
    assign ltu      = op_a < op_b;

`ifdef ALU_BARREL_SHIFT_EN
    alu_shift_step #(.XLEN(XLEN), .AMT_W(AW)) u_shift (
        .value_i (op_a),
        .amt_i   ({1'b0, shamt}),
        .op_i    (alu_ctrl),
        .value_o (shift_out)
    );
`else
    logic [AW-1:0] remaining_q, remaining_d;
    logic [AW-1:0] step_amt;
    logic [3:0]    op_q, op_d;

    // result_q doubles as the working register while shifting; out_valid is low then.
    assign step_amt = (remaining_q < AW'(SHIFT_STEP)) ? remaining_q : AW'(SHIFT_STEP);

    alu_shift_step #(.XLEN(XLEN), .AMT_W(AW)) u_shift (
        .value_i (result_q),
        .amt_i   (step_amt),
        .op_i    (op_q),
        .value_o (shift_out)
    );
`endif

    always_comb begin
        alu_res  = '0;
        alu_cond = 1'b0;
        alu_ill  = 1'b0;
        case (alu_ctrl)
            ALU_EQ:   alu_cond = (op_a == op_b);
            ALU_NE:   alu_cond = (op_a != op_b);
            ALU_SLT:  begin alu_cond = lt;  alu_res = XLEN'(lt);  end
            ALU_SLTU: begin alu_cond = ltu; alu_res = XLEN'(ltu); end
            ALU_GE:   alu_cond = !lt;
            ALU_GEU:  alu_cond = !ltu;
            ALU_ADD:  alu_res  = op_a + op_b;
            ALU_SUB:  alu_res  = op_a - op_b;
            ALU_XOR:  alu_res  = op_a ^ op_b;
            ALU_OR:   alu_res  = op_a | op_b;
            ALU_AND:  alu_res  = op_a & op_b;
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = shift_out;
`else
            // Only zero-amount shifts complete here; the rest go through SHIFT.
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op_a;
`endif
            default:  alu_ill  = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        cond_d      = cond_q;
        illegal_d   = illegal_q;
`ifndef ALU_BARREL_SHIFT_EN
        remaining_d = remaining_q;
        op_d        = op_q;
`endif
        case (state_q)
            ST_IDLE: ;
`ifndef ALU_BARREL_SHIFT_EN
            ST_SHIFT: begin
                result_d    = shift_out;
                remaining_d = remaining_q - step_amt;
                if (remaining_d == '0) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // A new operation overrides the retire path, giving 1/cycle streaming.
        if (accept) begin
`ifndef ALU_BARREL_SHIFT_EN
            if (is_shift && shamt != '0) begin
                state_d     = ST_SHIFT;
                out_valid_d = 1'b0;
                result_d    = op_a;
                cond_d      = 1'b0;
                illegal_d   = 1'b0;
                remaining_d = {1'b0, shamt};
                op_d        = alu_ctrl;
            end else
`endif
            begin
                state_d     = ST_DONE;
                out_valid_d = 1'b1;
                result_d    = alu_res;
                cond_d      = alu_cond;
                illegal_d   = alu_ill;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cond_q      <= 1'b0;
            illegal_q   <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            remaining_q <= '0;
            op_q        <= ALU_NOP;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            cond_q      <= cond_d;
            illegal_q   <= illegal_d;
`ifndef ALU_BARREL_SHIFT_EN
            remaining_q <= remaining_d;
            op_q        <= op_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cond      = cond_q;
    assign illegal   = illegal_q;

endmodule
